instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the instruction memory read address.
- Captures the returned instruction, with PC+4, into the IF/ID pipeline register for the decode stage.
- Handles decode-stage stalls and branch/jump redirects, including the flush of the wrong-path instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on reset or flush (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit request: hold PC and IF/ID.
- redirect_valid  input  1  branch taken or jump resolved this cycle.
- redirect_target  input  32  new PC when redirect_valid=1.
- imem_addr  output  32  byte address to instruction memory.
- imem_instr  input  32  instruction word returned for imem_addr.
- if_id_instr  output  32  registered instruction for the decode stage.
- if_id_pc_plus4  output  32  registered PC+4 of if_id_instr.
- if_id_valid  output  1  if_id_instr is a real fetched instruction, not a bubble.
- pc  output  32  current PC register.
- fetch_count  output  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- imem_addr = pc, combinational. The memory is asynchronous: imem_instr must be stable before the next rising edge. This sets the cycle time and is not handled by this block.
- Reset (reset=1 at a rising edge), taking priority over every other input:
  - pc <= RESET_PC
  - if_id_instr <= NOP_WORD
  - if_id_pc_plus4 <= 0
  - if_id_valid <= 0
  - fetch_count <= 0
- An asynchronous assertion of reset has no effect until the next edge.
- Per-edge priority when reset=0:
  - Redirect (redirect_valid=1), regardless of stall:
    - pc <= {redirect_target[31:2],2'b00}; low two target bits are ignored.
    - if_id_instr <= NOP_WORD, if_id_valid <= 0 (flush of the wrong-path instruction).
    - if_id_pc_plus4 <= 0.
    - fetch_count unchanged.
  - Stall (stall=1, redirect_valid=0): pc, all if_id_* outputs and fetch_count hold their values.
  - Normal:
    - pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
    - if_id_instr <= imem_instr, if_id_pc_plus4 <= pc + 4, if_id_valid <= 1.
    - fetch_count <= fetch_count + 1, wrapping modulo 2^32.
- Latency:
  - An instruction at address A appears on if_id_instr one edge after pc==A with no stall.
  - After a redirect edge, the target instruction reaches IF/ID on the following unstalled edge: exactly one bubble.
- Redirect and stall in the same cycle: redirect wins and the flush is applied. Stall in the following cycle then holds the bubble and the target PC.
- Back-to-back redirects: each one overwrites pc, and the IF/ID register stays a bubble throughout.
- There is no FSM beyond the implicit three-way next-state mux. All registers use one always block clocked on posedge clk with reset tested first.

Decomposition:
- Shared package mips_pkg holds:
  - constant NOP_WORD = 32'h0
  - constant RESET_PC = 32'h0
  - constant PC_INCR = 4
  - if_id_t struct {instr[31:0], pc_plus4[31:0], valid}, reused by the decode stage.
- One natural sub-module: pc_register, holding the PC flop with reset/redirect/stall/increment next-PC mux.
- The IF/ID register and fetch_count stay in the top module.
- The bench instantiates instruction_fetch_stage together with the existing instruction memory model preloaded from a .mem file.

Test Plan:
- Reset, then release with memory words 0x11111111, 0x22222222, 0x33333333 at addresses 0/4/8:
  - During reset: pc=0, if_id_valid=0, if_id_instr=0.
  - After 3 edges: if_id_instr=0x33333333, if_id_pc_plus4=12, pc=12, fetch_count=3.
- stall=1 for 2 cycles with pc=8: pc, if_id_instr, if_id_pc_plus4 and fetch_count are unchanged across both edges. On release, fetch resumes at 8 with no instruction lost or duplicated.
- redirect_valid=1, target=0x40 at pc=0x10:
  - Next edge: pc=0x40, if_id_valid=0, if_id_instr=0.
  - Following edge: if_id_instr=mem[0x40>>2], if_id_pc_plus4=0x44.
- redirect_valid=1 and stall=1 together, target=0x83: pc=0x80 (low bits masked), IF/ID flushed. Stall held for 1 more cycle keeps pc=0x80 and if_id_valid=0.
- Force pc=32'hFFFF_FFFC via redirect, then 1 unstalled edge: pc=0, if_id_pc_plus4=0.
- Assert reset mid-run with stall=1 and redirect_valid=1: all outputs return to reset values at that edge.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and IF/ID pipeline register type for the MIPS pipeline
package mips_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR  = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter flop with reset/redirect/stall/increment next-PC selection
module pc_register
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc
);

    logic [31:0] r_pc;

    // Redirect beats stall so a taken branch is never lost behind a hazard hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_target[31:2], 2'b00};
        end else if (!stall) begin
            r_pc <= r_pc + PC_INCR;
        end
    end

    assign pc = r_pc;

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: PC, instruction memory address, IF/ID register and fetch counter
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] pc,
    output logic [31:0] fetch_count
);

    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    if_id_t      r_if_id;
    logic [31:0] r_fetch_count;

    pc_register #(
        .RESET_PC(RESET_PC)
    ) u_pc_register (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .pc             (w_pc)
    );

    assign w_pc_plus4 = w_pc + PC_INCR;

    // A redirect flushes the wrong-path word already addressed this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_id.instr    <= NOP_WORD;
            r_if_id.pc_plus4 <= 32'h0;
            r_if_id.valid    <= 1'b0;
            r_fetch_count    <= 32'h0;
        end else if (redirect_valid) begin
            r_if_id.instr    <= NOP_WORD;
            r_if_id.pc_plus4 <= 32'h0;
            r_if_id.valid    <= 1'b0;
        end else if (!stall) begin
            r_if_id.instr    <= imem_instr;
            r_if_id.pc_plus4 <= w_pc_plus4;
            r_if_id.valid    <= 1'b1;
            r_fetch_count    <= r_fetch_count + 32'd1;
        end
    end

    assign imem_addr      = w_pc;
    assign pc             = w_pc;
    assign if_id_instr    = r_if_id.instr;
    assign if_id_pc_plus4 = r_if_id.pc_plus4;
    assign if_id_valid    = r_if_id.valid;
    assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed self-checking bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] pc;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:63];

    int n_tests = 0;
    int n_fail  = 0;

    instruction_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .pc             (pc),
        .fetch_count    (fetch_count)
    );

    // Asynchronous instruction memory model, 64 words aliased over the address space.
    assign imem_instr = mem[imem_addr[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic [31:0] e_pp4, input logic e_valid, input logic [31:0] e_fc);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".imem_addr"}, imem_addr, e_pc);
        check({tag, ".instr"}, if_id_instr, e_instr);
        check({tag, ".pc_plus4"}, if_id_pc_plus4, e_pp4);
        check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e_valid});
        check({tag, ".fetch_count"}, fetch_count, e_fc);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000 + i;
        mem[0] = 32'h1111_1111;
        mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333;

        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        step();
        step();
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        // Three sequential fetches from address 0.
        reset = 1'b0;
        step();
        check_state("fetch1", 32'h4, 32'h1111_1111, 32'h4, 1'b1, 32'd1);
        step();
        step();
        check_state("fetch3", 32'hC, 32'h3333_3333, 32'hC, 1'b1, 32'd3);

        // Back up to 4 so the stall happens with pc=8.
        redirect_valid = 1'b1;
        redirect_target = 32'h4;
        step();
        check_state("redir4", 32'h4, 32'h0, 32'h0, 1'b0, 32'd3);
        redirect_valid = 1'b0;
        step();
        check_state("pre_stall", 32'h8, 32'h2222_2222, 32'h8, 1'b1, 32'd4);

        stall = 1'b1;
        step();
        check_state("stall1", 32'h8, 32'h2222_2222, 32'h8, 1'b1, 32'd4);
        step();
        check_state("stall2", 32'h8, 32'h2222_2222, 32'h8, 1'b1, 32'd4);
        stall = 1'b0;
        step();
        check_state("unstall", 32'hC, 32'h3333_3333, 32'hC, 1'b1, 32'd5);
        step();
        check_state("to_0x10", 32'h10, 32'hC000_0003, 32'h10, 1'b1, 32'd6);

        // Redirect at pc=0x10 to 0x40: one bubble, then the target word.
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        step();
        check_state("redir40", 32'h40, 32'h0, 32'h0, 1'b0, 32'd6);
        redirect_valid = 1'b0;
        step();
        check_state("target40", 32'h44, 32'hC000_0010, 32'h44, 1'b1, 32'd7);

        // Redirect and stall together, unaligned target.
        redirect_valid = 1'b1;
        redirect_target = 32'h83;
        stall = 1'b1;
        step();
        check_state("redir_stall", 32'h80, 32'h0, 32'h0, 1'b0, 32'd7);
        redirect_valid = 1'b0;
        step();
        check_state("stall_bubble", 32'h80, 32'h0, 32'h0, 1'b0, 32'd7);
        stall = 1'b0;
        step();
        check_state("target80", 32'h84, 32'hC000_0020, 32'h84, 1'b1, 32'd8);

        // Back-to-back redirects keep the bubble.
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        step();
        redirect_target = 32'hFFFF_FFFC;
        step();
        check_state("redir_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd8);
        redirect_valid = 1'b0;
        step();
        check_state("pc_wrap", 32'h0, 32'hC000_003F, 32'h0, 1'b1, 32'd9);
        step();
        step();
        check_state("post_wrap", 32'h8, 32'h2222_2222, 32'h8, 1'b1, 32'd11);

        // Reset mid-run overrides stall and redirect.
        reset = 1'b1;
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        step();
        check_state("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
